// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR, SP and the compare
// flags, arbitrates the single memory port and turns decoder levels into strobes.
module cpu_sequencer #(
  parameter int AW = 10,
  parameter int DW = 16,
  parameter logic [AW-1:0] SP_INIT  = 10'h3FF,
  parameter logic [AW-1:0] RESET_PC = 10'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [DW-1:0] ir,
  input  logic          dec_halt,
  input  logic          dec_jump,
  input  logic          dec_neg,
  input  logic          dec_zero,
  input  logic          dec_compare,
  input  logic          dec_stack,
  input  logic          dec_mem_read,
  input  logic          dec_mem_write,
  input  logic          dec_alu_enable,
  input  logic          dec_reg_load,
  input  logic          dec_constant,
  input  logic [AW-1:0] dec_dout,
  input  logic          alu_neg,
  input  logic          alu_zero,
  input  logic [DW-1:0] reg_x_data,
  input  logic [DW-1:0] reg_y_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          reg_we,
  output logic          alu_go,
  output logic [DW-1:0] ld_data,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] sp,
  output logic          flag_n,
  output logic          flag_z,
  output logic          stack_err,
  output logic          halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;

  logic          is_write;
  logic          is_push;
  logic          is_pop;
  logic          guard_fail;
  logic          take;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] sp_up;
  logic [AW-1:0] sp_down;
  logic          unused_y_bits;

  // Decoder outputs are stable from DECODE through the end of the instruction,
  // so the same classification serves DECODE and MEM.
  always_comb begin
    is_write    = dec_mem_write;
    is_push     = dec_stack & dec_mem_write;
    is_pop      = dec_stack & dec_mem_read & ~dec_mem_write;
    guard_fail  = (is_push && (sp == '0)) || (is_pop && (sp == SP_INIT));
    take        = (~dec_neg & ~dec_zero) | (dec_neg & flag_n) | (dec_zero & flag_z);
    jump_target = dec_constant ? dec_dout : reg_x_data[AW-1:0];
    pc_inc      = pc + 1'b1;
    sp_up       = sp + 1'b1;
    sp_down     = sp - 1'b1;
  end

  assign unused_y_bits = ^reg_y_data[DW-1:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      sp        <= SP_INIT;
      ir        <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      ld_data   <= '0;
      stack_err <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reg_we    <= 1'b0;
      alu_go    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      alu_go <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end

        FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end

        DECODE: begin
          if (dec_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (dec_jump) begin
            if (take) pc <= jump_target;
            if (run) begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= take ? jump_target : pc;
            end else begin
              state <= IDLE;
            end
          end else if (dec_mem_read | dec_mem_write) begin
            // A failed stack guard enters MEM without raising a request.
            state     <= MEM;
            mem_req   <= ~guard_fail;
            mem_we    <= is_write & ~guard_fail;
            mem_addr  <= is_push ? sp : (is_pop ? sp_up : reg_y_data[AW-1:0]);
            mem_wdata <= reg_x_data;
          end else begin
            state  <= EXEC;
            alu_go <= dec_alu_enable;
            reg_we <= dec_reg_load;
          end
        end

        EXEC: begin
          if (dec_compare) begin
            flag_n <= alu_neg;
            flag_z <= alu_zero;
          end
          if (run) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else begin
            state <= IDLE;
          end
        end

        MEM: begin
          if (guard_fail) begin
            stack_err <= 1'b1;
            halted    <= 1'b1;
            state     <= HALT;
          end else if (mem_ack) begin
            if (is_push)     sp <= sp_down;
            else if (is_pop) sp <= sp_up;
            if (is_write) begin
              if (run) begin
                state    <= FETCH;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc;
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
              end
            end else begin
              ld_data <= mem_rdata;
              reg_we  <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= WB;
            end
          end
        end

        WB: begin
          if (run) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else begin
            state <= IDLE;
          end
        end

        HALT: begin
          halted <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed walk-throughs of each instruction class,
// then random programs scored against an instruction-level reference model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        dec_halt, dec_jump, dec_neg, dec_zero, dec_compare, dec_stack;
  logic        dec_mem_read, dec_mem_write, dec_alu_enable, dec_reg_load, dec_constant;
  logic [9:0]  dec_dout;
  logic        alu_neg, alu_zero;
  logic [15:0] reg_x_data, reg_y_data;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        reg_we, alu_go;
  logic [15:0] ld_data;
  logic [9:0]  pc, sp;
  logic        flag_n, flag_z, stack_err, halted;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic halt, jump, neg, zero, compare, stack, mrd, mwr, alu, rload, cnst;
    logic [9:0] dout;
  } ctl_t;

  typedef struct packed {
    logic       we;
    logic [9:0] addr;
    logic [15:0] wdata;
  } txn_t;

  // Stand-in instruction decoder: opcode in [15:12], constant select in bit 11.
  function automatic ctl_t decodeIr(input logic [15:0] w);
    ctl_t c;
    c      = '0;
    c.cnst = w[11];
    c.dout = w[9:0];
    case (w[15:12])
      4'h0: c.halt = 1'b1;
      4'h6: begin c.compare = 1'b1; c.alu = 1'b1; end
      4'h9: begin c.mrd = 1'b1; c.rload = 1'b1; end
      4'hA: c.mwr = 1'b1;
      4'hB: begin c.stack = 1'b1; c.mwr = 1'b1; end
      4'hC: begin c.stack = 1'b1; c.mrd = 1'b1; c.rload = 1'b1; end
      4'hD: c.jump = 1'b1;
      4'hE: begin c.jump = 1'b1; c.zero = 1'b1; end
      4'hF: begin c.jump = 1'b1; c.neg = 1'b1; end
      default: begin c.alu = 1'b1; c.rload = 1'b1; end
    endcase
    return c;
  endfunction

  // In random mode register data and ALU flags are pure functions of the instruction.
  function automatic logic [15:0] xOf(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction
  function automatic logic [15:0] yOf(input logic [15:0] w);
    return {6'b0, 2'b10, w[7:0]};
  endfunction

  bit          randMode = 1'b0;
  logic [15:0] xDrv = '0, yDrv = '0;
  logic        negDrv = 1'b0, zeroDrv = 1'b0;
  ctl_t        ctl;

  assign ctl            = decodeIr(ir);
  assign dec_halt       = ctl.halt;
  assign dec_jump       = ctl.jump;
  assign dec_neg        = ctl.neg;
  assign dec_zero       = ctl.zero;
  assign dec_compare    = ctl.compare;
  assign dec_stack      = ctl.stack;
  assign dec_mem_read   = ctl.mrd;
  assign dec_mem_write  = ctl.mwr;
  assign dec_alu_enable = ctl.alu;
  assign dec_reg_load   = ctl.rload;
  assign dec_constant   = ctl.cnst;
  assign dec_dout       = ctl.dout;
  assign reg_x_data     = randMode ? xOf(ir) : xDrv;
  assign reg_y_data     = randMode ? yOf(ir) : yDrv;
  assign alu_neg        = randMode ? ir[5] : negDrv;
  assign alu_zero       = randMode ? ir[6] : zeroDrv;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir),
    .dec_halt(dec_halt), .dec_jump(dec_jump), .dec_neg(dec_neg), .dec_zero(dec_zero),
    .dec_compare(dec_compare), .dec_stack(dec_stack), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_alu_enable(dec_alu_enable),
    .dec_reg_load(dec_reg_load), .dec_constant(dec_constant), .dec_dout(dec_dout),
    .alu_neg(alu_neg), .alu_zero(alu_zero), .reg_x_data(reg_x_data), .reg_y_data(reg_y_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .reg_we(reg_we), .alu_go(alu_go),
    .ld_data(ld_data), .pc(pc), .sp(sp), .flag_n(flag_n), .flag_z(flag_z),
    .stack_err(stack_err), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] tbMem[1024];
  logic [15:0] modelMem[1024];
  txn_t        expQ[$];
  int          fixedDelay = 0;
  bit          txnCheck = 1'b0;
  int          txnIdx = 0;
  bit          countEn = 1'b0;
  int          weCnt = 0, goCnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after 0..N wait cycles and scores each accepted access.
  initial begin : responder
    int  waitLeft;
    bit  newTxn;
    waitLeft  = 0;
    newTxn    = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst_n) begin
        newTxn = 1'b1;
      end else if (mem_req) begin
        if (newTxn) begin
          waitLeft = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 2));
          newTxn   = 1'b0;
        end
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          newTxn  = 1'b1;
          if (mem_we) tbMem[mem_addr] = mem_wdata;
          else        mem_rdata = tbMem[mem_addr];
          if (txnCheck) begin
            if (txnIdx < expQ.size())
              checkOutput("txn", 32'({mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)}),
                          32'(expQ[txnIdx]));
            else
              checkOutput("txn_extra", txnIdx, expQ.size());
            txnIdx++;
          end
        end else begin
          waitLeft--;
        end
      end
    end
  end

  initial begin : pulseCounter
    forever begin
      @(negedge clk);
      if (countEn) begin
        if (reg_we) weCnt++;
        if (alu_go) goCnt++;
      end
    end
  end

  // Resets the DUT, loads a three-word program at address 0, then starts it.
  task automatic applyStimulus(input logic [15:0] p0, input logic [15:0] p1,
                               input logic [15:0] p2, input int delay);
    randMode   = 1'b0;
    txnCheck   = 1'b0;
    fixedDelay = delay;
    run        = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("rst_async_outs", {mem_req, mem_we, reg_we, alu_go, halted}, 5'b0);
    for (int a = 0; a < 1024; a++) tbMem[a] = 16'h0;
    tbMem[0] = p0;
    tbMem[1] = p1;
    tbMem[2] = p2;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pc_sp_ir", {pc, sp, ir}, {10'h000, 10'h3FF, 16'h0000});
    checkOutput("rst_flags", {flag_n, flag_z, stack_err, ld_data}, 19'h0);
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  logic [9:0]  mpc, msp;
  logic        mfn, mfz, merr, mhalt;
  logic [15:0] mld;
  int          mRegWe, mAluGo;
  logic [3:0]  opTab[14] = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9,
                             4'hA, 4'hB, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  // Instruction-level reference: executes the program and records the access stream.
  task automatic runModel();
    logic [15:0] w, x, y;
    ctl_t        c;
    logic        tk;
    expQ.delete();
    mpc = 10'h000; msp = 10'h3FF; mfn = 0; mfz = 0; merr = 0; mhalt = 0; mld = '0;
    mRegWe = 0; mAluGo = 0;
    for (int n = 0; n < 1000 && !mhalt; n++) begin
      expQ.push_back({1'b0, mpc, 16'h0});
      w   = modelMem[mpc];
      mpc = mpc + 10'd1;
      c   = decodeIr(w);
      x   = xOf(w);
      y   = yOf(w);
      if (c.halt) begin
        mhalt = 1;
      end else if (c.jump) begin
        tk = (!c.neg && !c.zero) || (c.neg && mfn) || (c.zero && mfz);
        if (tk) mpc = c.cnst ? c.dout : x[9:0];
      end else if (c.stack && c.mwr) begin
        if (msp == 10'h000) begin merr = 1; mhalt = 1; end
        else begin
          expQ.push_back({1'b1, msp, x});
          modelMem[msp] = x;
          msp = msp - 10'd1;
        end
      end else if (c.stack && c.mrd) begin
        if (msp == 10'h3FF) begin merr = 1; mhalt = 1; end
        else begin
          msp = msp + 10'd1;
          expQ.push_back({1'b0, msp, 16'h0});
          mld = modelMem[msp];
          mRegWe++;
        end
      end else if (c.mwr) begin
        expQ.push_back({1'b1, y[9:0], x});
        modelMem[y[9:0]] = x;
      end else if (c.mrd) begin
        expQ.push_back({1'b0, y[9:0], 16'h0});
        mld = modelMem[y[9:0]];
        mRegWe++;
      end else begin
        if (c.alu)     mAluGo++;
        if (c.rload)   mRegWe++;
        if (c.compare) begin mfn = w[5]; mfz = w[6]; end
      end
    end
  endtask

  initial begin : main
    int         cnt;
    logic [3:0] op;
    logic [9:0] tgt;
    run   = 1'b0;
    rst_n = 1'b0;

    // ALU op, then halt and stay quiet.
    applyStimulus(16'h8055, 16'h0000, 16'h0000, 0);
    @(negedge clk);
    checkOutput("t1_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 10'h000});
    @(negedge clk);
    checkOutput("t1_decode_ir_pc", {ir, pc}, {16'h8055, 10'h001});
    checkOutput("t1_decode_quiet", {mem_req, reg_we, alu_go}, 3'b000);
    @(negedge clk);
    checkOutput("t1_exec_strobes", {reg_we, alu_go, mem_req}, 3'b110);
    @(negedge clk);
    checkOutput("t1_refetch", {reg_we, alu_go, mem_req, mem_addr}, {3'b001, 10'h001});
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1_halted", halted, 1'b1);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (mem_req) cnt++; end
    checkOutput("t1_halt_no_req", cnt, 0);
    checkOutput("t1_halt_pc", {halted, pc}, {1'b1, 10'h002});

    // Push then pop.
    xDrv = 16'hA5C3;
    applyStimulus(16'hB001, 16'hC002, 16'h0000, 0);
    repeat (3) @(negedge clk);
    checkOutput("t2_push_access", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 10'h3FF, 16'hA5C3});
    @(negedge clk);
    checkOutput("t2_push_sp", sp, 10'h3FE);
    repeat (2) @(negedge clk);
    checkOutput("t2_pop_access", {mem_req, mem_we, mem_addr}, {2'b10, 10'h3FF});
    @(negedge clk);
    checkOutput("t2_pop_wb", {reg_we, ld_data, sp}, {1'b1, 16'hA5C3, 10'h3FF});

    // Pop on an empty stack.
    applyStimulus(16'hC002, 16'h0000, 16'h0000, 0);
    repeat (3) @(negedge clk);
    checkOutput("t3_no_req", mem_req, 1'b0);
    @(negedge clk);
    checkOutput("t3_err_halt_sp", {stack_err, halted, sp}, {2'b11, 10'h3FF});

    // Compare then jump-if-equal, taken and not taken.
    zeroDrv = 1'b1;
    applyStimulus(16'h6012, 16'hE80A, 16'h0000, 0);
    repeat (4) @(negedge clk);
    checkOutput("t4_flags_set", {flag_n, flag_z}, 2'b01);
    repeat (2) @(negedge clk);
    checkOutput("t4_jump_taken", {pc, mem_req, mem_addr}, {10'h00A, 1'b1, 10'h00A});
    zeroDrv = 1'b0;
    applyStimulus(16'h6012, 16'hE80A, 16'h0000, 0);
    repeat (4) @(negedge clk);
    checkOutput("t4_flags_clear", {flag_n, flag_z}, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("t4_jump_not_taken", {pc, mem_req, mem_addr}, {10'h002, 1'b1, 10'h002});

    // Unconditional register-target jump.
    xDrv = 16'hF123;
    applyStimulus(16'hD000, 16'h0000, 16'h0000, 0);
    repeat (3) @(negedge clk);
    checkOutput("t7_reg_jump", {pc, mem_req, mem_addr}, {10'h123, 1'b1, 10'h123});

    // Slow fetch with run dropped mid-wait.
    applyStimulus(16'h8055, 16'h0000, 16'h0000, 3);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 10'h000 && pc == 10'h000 && ir == 16'h0) cnt++;
      if (i == 1) run = 1'b0;
    end
    checkOutput("t5_held_cycles", cnt, 4);
    @(negedge clk);
    checkOutput("t5_decode", {ir, pc}, {16'h8055, 10'h001});
    @(negedge clk);
    checkOutput("t5_exec", reg_we, 1'b1);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (mem_req) cnt++; end
    checkOutput("t5_idle", {cnt[7:0], halted, pc}, {8'd0, 1'b0, 10'h001});

    // Async reset during a stalled store.
    yDrv = 16'h0155;
    applyStimulus(16'hA000, 16'h0000, 16'h0000, 3);
    repeat (6) @(negedge clk);
    checkOutput("t6_in_mem", {mem_req, mem_we, mem_addr}, {2'b11, 10'h155});
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_clear", {mem_req, mem_we, halted, pc}, {3'b000, 10'h000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    checkOutput("t6_restart_fetch", {mem_req, mem_we, mem_addr}, {2'b10, 10'h000});

    // Random programs: forward-only jumps guarantee the run reaches a halt.
    for (int r = 0; r < 4; r++) begin
      run = 1'b0; rst_n = 1'b0; txnCheck = 1'b0; countEn = 1'b0;
      randMode = 1'b1; fixedDelay = -1;
      for (int a = 0; a < 1024; a++) tbMem[a] = (a >= 'h200) ? 16'($urandom) : 16'h0;
      for (int a = 0; a < 48; a++) begin
        op = opTab[$urandom_range(0, 13)];
        if (op >= 4'hD) begin
          tgt = 10'(a + 1 + int'($urandom_range(0, 4)));
          tbMem[a] = {op, 2'b10, tgt};
        end else begin
          tbMem[a] = {op, 12'($urandom)};
        end
      end
      modelMem = tbMem;
      runModel();
      txnIdx = 0; weCnt = 0; goCnt = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; run = 1'b1; txnCheck = 1'b1; countEn = 1'b1;
      cnt = 0;
      while (!halted && cnt < 3000) begin @(negedge clk); cnt++; end
      checkOutput("rand_halted", halted, 1'b1);
      checkOutput("rand_txn_count", txnIdx, expQ.size());
      checkOutput("rand_pc_sp", {pc, sp}, {mpc, msp});
      checkOutput("rand_flags_err", {flag_n, flag_z, stack_err}, {mfn, mfz, merr});
      checkOutput("rand_ld_data", ld_data, mld);
      checkOutput("rand_reg_we_count", weCnt, mRegWe);
      checkOutput("rand_alu_go_count", goCnt, mAluGo);
      txnCheck = 1'b0;
      countEn  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the CPU core.
- Holds PC, IR, SP and the compare flags. Feeds IR to the instruction decoder and turns the decoder's level-valued control outputs into single-cycle strobes.
- Arbitrates the single memory port between instruction fetch and load/store/push/pop data accesses.
- Sits between program/data memory, the decoder, the register file and the ALU.

Parameters:
AW, 10, memory address / PC / SP width
DW, 16, instruction and data word width
SP_INIT, 10'h3FF, stack pointer value after reset (empty stack)
RESET_PC, 10'h000, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start/continue execution
ir  out  DW  instruction register; [15:12] is the decoder opcode, [11:0] is the decoder dataIn
dec_halt, dec_jump, dec_neg, dec_zero, dec_compare, dec_stack, dec_mem_read, dec_mem_write, dec_alu_enable, dec_reg_load, dec_constant  in  1 each  decoder control outputs
dec_dout  in  AW  decoder constant/jump target
alu_neg, alu_zero  in  1  ALU result flags
reg_x_data, reg_y_data  in  DW  register-file read data for regX/regY
mem_req  out  1  memory request
mem_we  out  1  write enable (valid with mem_req)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  request accepted/complete
reg_we  out  1  one-cycle register-file write strobe
alu_go  out  1  one-cycle ALU enable strobe
ld_data  out  DW  captured memory read data for register writeback
pc, sp  out  AW  current PC / SP
flag_n, flag_z  out  1  latched compare flags
stack_err  out  1  sticky stack overflow/underflow
halted  out  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, sp=SP_INIT, ir=0, flags=0, ld_data=0, stack_err=0. All strobes, mem_req, mem_we and halted are 0 immediately.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: on run=1, go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc, held until mem_ack.
  - mem_ack is sampled while mem_req=1; an ack in the same cycle as the request is legal.
  - On ack: ir<=mem_rdata; pc<=pc+1, wrapping 3FF->000; go to DECODE.
- DECODE: exactly one cycle, during which decoder outputs settle. Priority order:
  - dec_halt: go to HALT.
  - dec_jump:
    - take = (!dec_neg & !dec_zero) | (dec_neg & flag_n) | (dec_zero & flag_z).
    - target = dec_constant ? dec_dout : reg_x_data[AW-1:0].
    - If take, pc<=target.
    - Next state is FETCH, or IDLE if run=0. dec_compare is ignored on jumps; flags are unchanged.
  - dec_mem_read | dec_mem_write: go to MEM.
  - Otherwise: go to EXEC.
- EXEC (one cycle):
  - alu_go=dec_alu_enable; reg_we=dec_reg_load.
  - If dec_compare: flag_n<=alu_neg, flag_z<=alu_zero.
  - Next state is FETCH, or IDLE if run=0.
- MEM addressing (mem_addr and mem_wdata held stable until ack):
  - Load: addr=reg_y_data[AW-1:0].
  - Store: addr=reg_y_data[AW-1:0], wdata=reg_x_data, mem_we=1.
  - Push: addr=sp, wdata=reg_x_data, mem_we=1; on ack sp<=sp-1.
  - Pop: addr=sp+1; on ack sp<=sp+1.
  - On a read ack: ld_data<=mem_rdata, go to WB. On a write ack: go to FETCH, or IDLE if run=0.
- Stack guards, checked on MEM entry with no request issued:
  - Push with sp==0 sets stack_err and goes to HALT.
  - Pop with sp==SP_INIT sets stack_err and goes to HALT.
- WB (one cycle): reg_we=1; next state is FETCH, or IDLE if run=0.
- HALT: halted=1, no memory requests; leave only via reset.
- run=0 never aborts an outstanding memory request; it is honoured only at instruction boundaries.
- Instruction latency with zero-wait memory: ALU op 3 cycles (FETCH, DECODE, EXEC); jump 2; store/push 3; load/pop 4.

Test Plan:
- Reset, run=1, memory returns 16'h8055 with 0-wait ack -> cycle-by-cycle FETCH, DECODE, EXEC; reg_we pulses once in EXEC; pc 000->001; ir=8055.
- Push 16'hB001 after reset -> mem_we=1, mem_addr=3FF, mem_wdata=reg_x_data, sp=3FE. Then pop 16'hC002 -> mem_addr=3FF, ld_data=mem_rdata, reg_we in WB, sp=3FF.
- Pop immediately after reset (sp=3FF) -> no mem_req in MEM, stack_err=1, halted=1, sp stays 3FF.
- Comp 16'h6012 with alu_zero=1 -> flag_z=1; then jmpe 16'hE80A -> pc=00A. Repeat with alu_zero=0 -> pc increments normally.
- FETCH with mem_ack delayed 3 cycles -> mem_req, mem_addr held stable for 4 cycles; pc and ir unchanged until the ack cycle; run dropped mid-wait -> instruction completes, then IDLE.
- Fetch 16'h0000 -> HALT, halted=1, no mem_req with run=1 for 20 cycles. Separately, rst_n low during MEM -> mem_req=0 and state=IDLE without waiting for clk.
